uart_tx_framer: RTL and testbench
=================================

Name: uart_tx_framer

Overview:
Response-frame builder on the transmit side of the UART-to-core bridge, directly downstream of the core result path and upstream of the UART byte transmitter.
- Accepts one response (cmd, len, payload) per handshake.
- Serialises it as header 0x55, cmd, len, then payload bytes LSB-first, one byte per transmitter slot.
- Carries nonce reports (cmd 0x00) and loop-test acks (cmd 0x01) back to the host.

Parameters:
MAX_BYTES, 4, payload capacity in bytes; must be 1..255.
HEADER, 8'h55, first byte of every response frame.

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  1  response request valid.
req_ready  output  1  framer can accept a request (high only in IDLE).
req_cmd  input  8  command byte.
req_len  input  8  requested payload length in bytes.
req_data  input  MAX_BYTES*8  payload; byte 0 = bits [7:0], sent first.
tx_data  output  8  byte to UART transmitter.
new_tx_data  output  1  one-cycle strobe; tx_data is valid this cycle.
tx_busy  input  1  UART transmitter busy shifting a byte.
frame_done  output  1  one-cycle pulse after the last byte of a frame is issued.
busy  output  1  high from request accept until frame_done.

Behaviour:
- Reset (async, rst_n low): state IDLE; tx_data=0, new_tx_data=0, frame_done=0, busy=0, req_ready=1 after release; internal cmd/len/payload registers and byte counter cleared.
- Accept: in IDLE, req_valid & req_ready captures req_cmd, eff_len = min(req_len, MAX_BYTES), and req_data into registers. Next cycle: busy=1, req_ready=0. Inputs are don't-care after capture.
- States: IDLE -> HDR -> CMD -> LEN -> DATA -> (CSUM if enabled) -> DONE -> IDLE.
- Each byte state issues its byte when tx_busy=0:
  - new_tx_data=1 for exactly one cycle with tx_data = byte.
  - Then a 1-cycle guard (tx_busy ignored, since the UART raises busy the cycle after the strobe).
  - Then wait for tx_busy=0 before the next byte.
  - Minimum spacing between strobes is 2 cycles when tx_busy never asserts.
- HDR sends HEADER; CMD sends the captured cmd; LEN sends eff_len (the clamped value, not req_len).
- DATA:
  - Sends eff_len bytes: payload register shifts right 8 after each issue; byte counter decrements.
  - eff_len=0 skips DATA entirely.
- DONE: frame_done=1 for one cycle, busy=0; returns to IDLE with req_ready=1 the following cycle. No back-to-back accept in the DONE cycle.
- tx_busy held high stalls indefinitely in the wait; no timeout, no byte dropped.
- req_valid during a frame is ignored (not queued); the requester holds it until req_ready.
- rst_n asserted mid-frame aborts immediately; no partial-frame completion, no frame_done.
- Clamping: req_len > MAX_BYTES sends LEN=MAX_BYTES and MAX_BYTES payload bytes.

Optional Feature:
Macro UART_FRAME_CSUM_EN.
- Defined: an XOR checksum of cmd, eff_len and all sent payload bytes is accumulated as bytes issue. It is sent in CSUM after the last payload byte, same handshake; frame_done follows it. LEN still counts payload only.
- Undefined: no CSUM state, no accumulator; frame ends after the last payload byte.

Test Plan:
- Nonce report: cmd 0x00, len 4, data 32'h12345678, tx_busy model 10 cycles/byte -> strobes 55 00 04 78 56 34 12, single frame_done after 0x12; busy high throughout.
- Loop ack: cmd 0x01, len 1, data 0xA5 -> 55 01 01 A5; with UART_FRAME_CSUM_EN -> 55 01 01 A5 A5 (0x01^0x01^0xA5).
- Zero/clamp: len 0 -> 55 02 00 only; len 9 with MAX_BYTES=4, data 32'hDDCCBBAA -> 55 02 04 AA BB CC DD.
- Backpressure: tx_busy forced high 200 cycles after header -> no new_tx_data during hold; CMD byte issued within 1 cycle of release; no byte lost or duplicated.
- Request while busy: second req_valid pulsed mid-frame -> ignored, req_ready=0; held request is accepted the cycle after return to IDLE, and its frame follows intact.
- Reset mid-frame: rst_n low after LEN byte -> outputs zero immediately, no frame_done; next request produces a complete fresh frame starting with 0x55.

Source files
------------

// File: rtl/uart_tx_framer_if.sv
// Response-frame bus between the core result path, the framer and the UART
// byte transmitter.
//   master : requester side (drives the request) plus the UART (drives tx_busy)
//   slave  : the framer
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high; the requester holds req_valid and the request
// fields stable until that edge. new_tx_data is a one-cycle strobe with
// tx_data valid in the same cycle; tx_busy is the transmitter's back-pressure.
interface uart_tx_framer_if #(
  parameter int MAX_BYTES = 4
);
  logic                   req_valid;
  logic                   req_ready;
  logic [7:0]             req_cmd;
  logic [7:0]             req_len;
  logic [MAX_BYTES*8-1:0] req_data;
  logic [7:0]             tx_data;
  logic                   new_tx_data;
  logic                   tx_busy;
  logic                   frame_done;
  logic                   busy;

  modport master (
    output req_valid, req_cmd, req_len, req_data, tx_busy,
    input  req_ready, tx_data, new_tx_data, frame_done, busy
  );

  modport slave (
    input  req_valid, req_cmd, req_len, req_data, tx_busy,
    output req_ready, tx_data, new_tx_data, frame_done, busy
  );
endinterface

// File: rtl/uart_tx_framer.sv
// UART response-frame builder.
// Frame: HEADER, cmd, eff_len, payload bytes LSB-first, where
// eff_len = min(req_len, MAX_BYTES). One byte is offered per transmitter slot:
// strobe, one guard cycle (the UART raises tx_busy a cycle after the strobe),
// then wait for tx_busy low before the next byte.
// Optional feature, macro UART_FRAME_CSUM_EN: appends an XOR checksum of cmd,
// eff_len and the payload bytes after the last payload byte.
// dbg_state exposes the FSM state encoding for checkers.
module uart_tx_framer #(
  parameter int         MAX_BYTES = 4,
  parameter logic [7:0] HEADER    = 8'h55
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_framer_if.slave   bus,
  output logic [2:0]        dbg_state
);

  localparam int         PW      = MAX_BYTES * 8;
  localparam logic [7:0] MAX_LEN = 8'(MAX_BYTES);

`ifdef UART_FRAME_CSUM_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_CMD  = 3'd2,
    S_LEN  = 3'd3,
    S_DATA = 3'd4,
    S_CSUM = 3'd5,
    S_DONE = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_CMD  = 3'd2,
    S_LEN  = 3'd3,
    S_DATA = 3'd4,
    S_DONE = 3'd6
  } state_t;
`endif

  state_t          state;
  state_t          nxt_state;
  state_t          tail_state;
  logic            guard;
  logic [7:0]      cmd_q;
  logic [7:0]      len_q;
  logic [7:0]      cnt_q;
  logic [PW-1:0]   payload_q;
  logic [7:0]      cur_byte;
  logic [7:0]      eff_len;
`ifdef UART_FRAME_CSUM_EN
  logic [7:0]      csum_q;
`endif

  // Length is clamped at capture so LEN and the data count always agree.
  assign eff_len   = (bus.req_len > MAX_LEN) ? MAX_LEN : bus.req_len;
  assign dbg_state = state;

`ifdef UART_FRAME_CSUM_EN
  assign tail_state = S_CSUM;
`else
  assign tail_state = S_DONE;
`endif

  // Byte to offer in the current state and where to go once it is issued.
  always_comb begin
    cur_byte  = 8'h00;
    nxt_state = state;
    case (state)
      S_HDR: begin
        cur_byte  = HEADER;
        nxt_state = S_CMD;
      end
      S_CMD: begin
        cur_byte  = cmd_q;
        nxt_state = S_LEN;
      end
      S_LEN: begin
        cur_byte  = len_q;
        nxt_state = (len_q == 8'd0) ? tail_state : S_DATA;
      end
      S_DATA: begin
        cur_byte  = payload_q[7:0];
        nxt_state = (cnt_q == 8'd1) ? tail_state : S_DATA;
      end
`ifdef UART_FRAME_CSUM_EN
      S_CSUM: begin
        cur_byte  = csum_q;
        nxt_state = S_DONE;
      end
`endif
      default: ;
    endcase
  end

  // Frame FSM with registered handshake, strobe and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      guard           <= 1'b0;
      cmd_q           <= 8'h00;
      len_q           <= 8'h00;
      cnt_q           <= 8'h00;
      payload_q       <= '0;
`ifdef UART_FRAME_CSUM_EN
      csum_q          <= 8'h00;
`endif
      bus.req_ready   <= 1'b1;
      bus.tx_data     <= 8'h00;
      bus.new_tx_data <= 1'b0;
      bus.frame_done  <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      bus.new_tx_data <= 1'b0;
      bus.frame_done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            cmd_q         <= bus.req_cmd;
            len_q         <= eff_len;
            cnt_q         <= eff_len;
            payload_q     <= bus.req_data;
`ifdef UART_FRAME_CSUM_EN
            csum_q        <= 8'h00;
`endif
            guard         <= 1'b0;
            bus.req_ready <= 1'b0;
            bus.busy      <= 1'b1;
            state         <= S_HDR;
          end
        end
        S_DONE: begin
          // First cycle is the guard after the last strobe; frame_done is
          // visible in the second, before req_ready reopens in IDLE.
          if (guard) begin
            guard          <= 1'b0;
            bus.frame_done <= 1'b1;
            bus.busy       <= 1'b0;
          end else begin
            bus.req_ready <= 1'b1;
            state         <= S_IDLE;
          end
        end
        default: begin
          if (guard) begin
            guard <= 1'b0;
          end else if (!bus.tx_busy) begin
            bus.tx_data     <= cur_byte;
            bus.new_tx_data <= 1'b1;
            guard           <= 1'b1;
            state           <= nxt_state;
            if (state == S_DATA) begin
              payload_q <= payload_q >> 8;
              cnt_q     <= cnt_q - 8'd1;
            end
`ifdef UART_FRAME_CSUM_EN
            if (state == S_CMD || state == S_LEN || state == S_DATA) begin
              csum_q <= csum_q ^ cur_byte;
            end
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer. A small UART model drives tx_busy for
// busy_len cycles after each strobe (or holds it while hold_busy is set); a
// monitor collects strobed bytes into got_q, and each test compares them
// against exp_q built from hand-derived frames.
module tb_uart_tx_framer;
  localparam int MAX_BYTES = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg_state;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  int cyc = 0;
  int frame_cnt = 0;
  int busy_errs = 0;
  int last_strobe = -1;
  int min_gap = 1000;
  int busy_len = 0;
  int uart_cnt = 0;
  bit hold_busy = 1'b0;

  uart_tx_framer_if #(.MAX_BYTES(MAX_BYTES)) bus ();

  uart_tx_framer #(.MAX_BYTES(MAX_BYTES), .HEADER(8'h55)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // UART model: busy for busy_len cycles after each strobe, or held high.
  always @(negedge clk) begin
    if (hold_busy) begin
      uart_cnt = 0;
      bus.tx_busy = 1'b1;
    end else if (uart_cnt > 0) begin
      uart_cnt--;
      bus.tx_busy = (uart_cnt != 0);
    end else begin
      bus.tx_busy = 1'b0;
    end
    if (bus.new_tx_data && busy_len > 0 && !hold_busy) begin
      uart_cnt = busy_len;
      bus.tx_busy = 1'b1;
    end
  end

  // monitor: byte capture, busy-at-strobe, frame_done count, strobe spacing
  always @(negedge clk) begin
    if (bus.new_tx_data) begin
      got_q.push_back(bus.tx_data);
      if (!bus.busy) busy_errs++;
      if (last_strobe >= 0 && (cyc - last_strobe) < min_gap) min_gap = cyc - last_strobe;
      last_strobe = cyc;
    end
    if (bus.frame_done) begin
      frame_cnt++;
      if (bus.busy) busy_errs++;
    end
  end

  // expected frame: 55, cmd, min(len,MAX), payload LSB-first (+ xor checksum)
  function automatic void build_exp(input logic [7:0] cmd, input logic [7:0] len,
                                    input logic [31:0] data);
    logic [7:0] eff;
    logic [7:0] cs;
    eff = (len > 8'(MAX_BYTES)) ? 8'(MAX_BYTES) : len;
    exp_q.push_back(8'h55);
    exp_q.push_back(cmd);
    exp_q.push_back(eff);
    cs = cmd ^ eff;
    for (int i = 0; i < int'(eff); i++) begin
      exp_q.push_back(data[8*i +: 8]);
      cs = cs ^ data[8*i +: 8];
    end
`ifdef UART_FRAME_CSUM_EN
    exp_q.push_back(cs);
`endif
  endfunction

  // driver: present a request, hold until accepted, then drop it
  task automatic send_req(input logic [7:0] cmd, input logic [7:0] len, input logic [31:0] data);
    int waited;
    waited = 0;
    @(negedge clk);
    bus.req_cmd   = cmd;
    bus.req_len   = len;
    bus.req_data  = data;
    bus.req_valid = 1'b1;
    while (!bus.req_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    vectors++;
    if (bus.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL accept_timeout: req_ready=%0b after %0d cycles, required 1", bus.req_ready, waited);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // driver: wait (bounded) for the frame_done cycle
  task automatic wait_done(input int limit);
    int waited;
    waited = 0;
    while (!bus.frame_done && waited < limit) begin
      @(negedge clk);
      waited++;
    end
    vectors++;
    if (bus.frame_done !== 1'b1) begin
      miscompares++;
      $display("FAIL frame_done_timeout: frame_done=%0b after %0d cycles, required 1", bus.frame_done, waited);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready: got %0b, expected 1", bus.req_ready); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b, expected 0", bus.busy); end
    vectors++; if (bus.new_tx_data !== 1'b0) begin miscompares++; $display("FAIL reset_new_tx_data: got %0b, expected 0", bus.new_tx_data); end
    vectors++; if (bus.tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_tx_data: got %h, expected 00", bus.tx_data); end
    vectors++; if (bus.frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done: got %0b, expected 0", bus.frame_done); end
    vectors++; if (dbg_state !== 3'd0) begin miscompares++; $display("FAIL reset_state: got %0d, expected 0", dbg_state); end
  endtask

  task automatic test_nonce();
    int n;
    busy_len = 10;
    got_q.delete(); exp_q.delete();
    busy_errs = 0;
    n = frame_cnt;
    send_req(8'h00, 8'd4, 32'h12345678);
    wait_done(2000);
    @(negedge clk);
    build_exp(8'h00, 8'd4, 32'h12345678);
    vectors++;
    if (got_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL nonce_count: got %0d bytes, expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL nonce_byte%0d: got %h, expected %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]); end
    end
    vectors++; if (frame_cnt !== n + 1) begin miscompares++; $display("FAIL nonce_frame_done: got %0d pulses, expected 1", frame_cnt - n); end
    vectors++; if (busy_errs !== 0) begin miscompares++; $display("FAIL nonce_busy: got %0d busy errors, expected 0", busy_errs); end
  endtask

  task automatic test_loop_ack();
    busy_len = 3;
    got_q.delete(); exp_q.delete();
    send_req(8'h01, 8'd1, 32'h000000A5);
    wait_done(500);
    @(negedge clk);
    build_exp(8'h01, 8'd1, 32'h000000A5);
    vectors++;
    if (got_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL loop_count: got %0d bytes, expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL loop_byte%0d: got %h, expected %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]); end
    end
  endtask

  task automatic test_zero_clamp();
    busy_len = 0;
    got_q.delete(); exp_q.delete();
    last_strobe = -1;
    min_gap = 1000;
    send_req(8'h02, 8'd0, 32'h0000_0000);
    wait_done(500);
    send_req(8'h02, 8'd9, 32'hDDCCBBAA);
    wait_done(500);
    @(negedge clk);
    build_exp(8'h02, 8'd0, 32'h0);
    build_exp(8'h02, 8'd9, 32'hDDCCBBAA);
    vectors++;
    if (got_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL zero_clamp_count: got %0d bytes, expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL zero_clamp_byte%0d: got %h, expected %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]); end
    end
    vectors++; if (min_gap !== 2) begin miscompares++; $display("FAIL strobe_spacing: got %0d cycles, expected 2", min_gap); end
  endtask

  task automatic test_backpressure();
    int lat;
    int waited;
    busy_len = 3;
    got_q.delete(); exp_q.delete();
    send_req(8'h03, 8'd2, 32'h0000_2211);
    waited = 0;
    while (got_q.size() < 1 && waited < 100) begin @(negedge clk); waited++; end
    hold_busy = 1'b1;
    repeat (200) @(negedge clk);
    vectors++; if (got_q.size() !== 1) begin miscompares++; $display("FAIL bp_hold: got %0d bytes during hold, expected 1", got_q.size()); end
    hold_busy = 1'b0;
    lat = 0;
    while (got_q.size() < 2 && lat < 10) begin @(negedge clk); lat++; end
    vectors++; if (lat > 3) begin miscompares++; $display("FAIL bp_release: got latency %0d, expected <= 3", lat); end
    wait_done(500);
    @(negedge clk);
    build_exp(8'h03, 8'd2, 32'h0000_2211);
    vectors++;
    if (got_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL bp_count: got %0d bytes, expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL bp_byte%0d: got %h, expected %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]); end
    end
  endtask

  task automatic test_req_while_busy();
    int waited;
    busy_len = 4;
    got_q.delete(); exp_q.delete();
    send_req(8'h04, 8'd1, 32'h0000_0077);
    waited = 0;
    while (got_q.size() < 2 && waited < 100) begin @(negedge clk); waited++; end
    bus.req_cmd = 8'h0E; bus.req_len = 8'd1; bus.req_data = 32'hEE; bus.req_valid = 1'b1;
    vectors++; if (bus.req_ready !== 1'b0) begin miscompares++; $display("FAIL rwb_ready_mid: got %0b, expected 0", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    bus.req_cmd = 8'h05; bus.req_len = 8'd2; bus.req_data = 32'h0000_9988; bus.req_valid = 1'b1;
    wait_done(500);
    vectors++; if (bus.req_ready !== 1'b0) begin miscompares++; $display("FAIL rwb_ready_done: got %0b, expected 0", bus.req_ready); end
    @(negedge clk);
    vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL rwb_ready_idle: got %0b, expected 1", bus.req_ready); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rwb_busy_idle: got %0b, expected 0", bus.busy); end
    @(negedge clk);
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL rwb_accept: got busy %0b, expected 1", bus.busy); end
    bus.req_valid = 1'b0;
    wait_done(500);
    @(negedge clk);
    build_exp(8'h04, 8'd1, 32'h0000_0077);
    build_exp(8'h05, 8'd2, 32'h0000_9988);
    vectors++;
    if (got_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL rwb_count: got %0d bytes, expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rwb_byte%0d: got %h, expected %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int waited;
    busy_len = 3;
    got_q.delete(); exp_q.delete();
    n = frame_cnt;
    send_req(8'h06, 8'd3, 32'h0033_2211);
    waited = 0;
    while (got_q.size() < 3 && waited < 100) begin @(negedge clk); waited++; end
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.tx_data !== 8'h00) begin miscompares++; $display("FAIL rmid_tx_data: got %h, expected 00", bus.tx_data); end
    vectors++; if (bus.new_tx_data !== 1'b0) begin miscompares++; $display("FAIL rmid_new_tx_data: got %0b, expected 0", bus.new_tx_data); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rmid_busy: got %0b, expected 0", bus.busy); end
    vectors++; if (dbg_state !== 3'd0) begin miscompares++; $display("FAIL rmid_state: got %0d, expected 0", dbg_state); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    vectors++; if (frame_cnt !== n) begin miscompares++; $display("FAIL rmid_no_done: got %0d pulses, expected 0", frame_cnt - n); end
    vectors++; if (got_q.size() !== 3) begin miscompares++; $display("FAIL rmid_no_bytes: got %0d bytes, expected 3", got_q.size()); end
    got_q.delete();
    send_req(8'h07, 8'd1, 32'h0000_003C);
    wait_done(500);
    @(negedge clk);
    build_exp(8'h07, 8'd1, 32'h0000_003C);
    vectors++;
    if (got_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL rmid_fresh_count: got %0d bytes, expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rmid_fresh_byte%0d: got %h, expected %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]); end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_cmd   = 8'h00;
    bus.req_len   = 8'h00;
    bus.req_data  = '0;
    bus.tx_busy   = 1'b0;
    test_reset();
    test_nonce();
    test_loop_ack();
    test_zero_clamp();
    test_backpressure();
    test_req_while_busy();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // watchdog: the run must never hang
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
